// File: rtl/riscv_pkg.sv
// Shared memory-interface types for the core's data-side responder.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

    localparam int unsigned BYTE_LANES = 4;
    localparam logic [3:0]  LANES_NONE = 4'b0000;
    localparam logic [3:0]  LANES_BYTE = 4'b0001;
    localparam logic [3:0]  LANES_HALF = 4'b0011;
    localparam logic [3:0]  LANES_WORD = 4'b1111;

    // Byte-enable mask for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] off);
        logic [3:0] mask;
        unique case (size)
            MEM_BYTE: mask = LANES_BYTE << off;
            MEM_HALF: mask = LANES_HALF << {off[1], 1'b0};
            MEM_WORD: mask = LANES_WORD;
            default:  mask = LANES_NONE;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_bank.sv
// Word-organised data storage: byte-enable write, registered read; never reset.
module data_mem_bank
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTE_LANES; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// performs the access and pulses a one-cycle response.
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  mem_size_e   req_size,
    input  logic        req_usign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  LAT_M1 = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    mem_resp_state_e state, next_state;
    logic [2:0]      cnt, cnt_next;

    logic            cap_write, cap_usign;
    logic [31:0]     cap_addr, cap_wdata;
    mem_size_e       cap_size;

    logic            cur_write, cur_usign, cur_err;
    logic [31:0]     cur_addr, cur_wdata, lane_wdata;
    mem_size_e       cur_size;
    logic            idle, enter_resp, do_access;

    logic            resp_load, resp_usign;
    mem_size_e       resp_size;
    logic [1:0]      resp_off;
    logic [31:0]     bank_rdata, load_data;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;

    assign idle       = (state == IDLE);
    assign req_ready  = idle;
    assign resp_valid = (state == RESP);

    // With LATENCY=0 the access happens on the accept edge itself, so in IDLE
    // the live request drives the datapath instead of the captured copy.
    assign cur_write = idle ? req_write : cap_write;
    assign cur_addr  = idle ? req_addr  : cap_addr;
    assign cur_wdata = idle ? req_wdata : cap_wdata;
    assign cur_size  = idle ? req_size  : cap_size;
    assign cur_usign = idle ? req_usign : cap_usign;

    always_comb begin
        cur_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
        unique case (cur_size)
            MEM_HALF: cur_err = cur_err | cur_addr[0];
            MEM_WORD: cur_err = cur_err | (|cur_addr[1:0]);
            default:  ;
        endcase
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (cur_err || LATENCY == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) next_state = RESP;
                else           cnt_next   = cnt - 3'd1;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign do_access  = enter_resp && !cur_err;

    always_comb begin
        unique case (cur_size)
            MEM_BYTE: lane_wdata = {4{cur_wdata[7:0]}};
            MEM_HALF: lane_wdata = {2{cur_wdata[15:0]}};
            default:  lane_wdata = cur_wdata;
        endcase
    end

    data_mem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk  (clk),
        .addr (cur_addr[AW+1:2]),
        .we   ((do_access && cur_write) ? lane_mask(cur_size, cur_addr[1:0]) : LANES_NONE),
        .wdata(lane_wdata),
        .rd_en(do_access && !cur_write),
        .rdata(bank_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_load  <= 1'b0;
            resp_err   <= 1'b0;
            resp_size  <= MEM_WORD;
            resp_usign <= 1'b0;
            resp_off   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (enter_resp) begin
                resp_load  <= !cur_err && !cur_write;
                resp_err   <= cur_err;
                resp_size  <= cur_size;
                resp_usign <= cur_usign;
                resp_off   <= cur_addr[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (idle && req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_size  <= req_size;
            cap_usign <= req_usign;
        end
    end

    assign sel_byte = bank_rdata[{resp_off, 3'b000} +: 8];
    assign sel_half = resp_off[1] ? bank_rdata[31:16] : bank_rdata[15:0];

    always_comb begin
        unique case (resp_size)
            MEM_BYTE: load_data = {{24{!resp_usign & sel_byte[7]}}, sel_byte};
            MEM_HALF: load_data = {{16{!resp_usign & sel_half[15]}}, sel_half};
            default:  load_data = bank_rdata;
        endcase
    end

    assign resp_rdata = resp_load ? load_data : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of loads/stores at LATENCY=2 plus
// reset-cancel and back-to-back throughput sequences (second DUT at LATENCY=0).
module tb_data_mem_responder;
    import riscv_pkg::*;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        mem_size_e   size;
        logic        usign;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, req_usign;
    logic [31:0] req_addr, req_wdata;
    mem_size_e   req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_valid, z_ready, z_write, z_usign;
    logic [31:0] z_addr, z_wdata;
    mem_size_e   z_size;
    logic        z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_usign(req_usign), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_size(z_size),
        .req_usign(z_usign), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    exp_t        sb[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input mem_size_e s, input logic u,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v = '{write: w, addr: a, wdata: d, size: s, usign: u, exp_rdata: er, exp_err: ee};
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    endtask

    // Drive one request, score its response, then confirm the outputs hold.
    task automatic do_req(input vec_t v, input string name);
        exp_t e;
        int   n;
        req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        req_size  = v.size;  req_usign = v.usign;
        req_valid = 1'b1;
        wait_ready();
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        e.cycles = v.exp_err ? 1 : int'(LAT) + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({name, "_latency"}, 32'(n), 32'(e.cycles));
        check({name, "_rdata"}, resp_rdata, e.rdata);
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
        @(posedge clk); #1;
        check({name, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
        check({name, "_rdata_hold"}, resp_rdata, e.rdata);
        check({name, "_err_hold"}, {31'b0, resp_err}, {31'b0, e.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, accepts;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = MEM_WORD; req_usign = 1'b0;
        z_valid = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0;
        z_size = MEM_WORD; z_usign = 1'b0;

        vecs.push_back(mk(1, 32'h10,   32'hDEADBEEF, MEM_WORD, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        MEM_WORD, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h13,   32'h80,       MEM_BYTE, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h13,   32'h0,        MEM_BYTE, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 32'h13,   32'h0,        MEM_BYTE, 1, 32'h00000080, 0));
        vecs.push_back(mk(0, 32'h10,   32'h0,        MEM_WORD, 0, 32'h80ADBEEF, 0));
        vecs.push_back(mk(0, 32'h11,   32'h0,        MEM_HALF, 0, 32'h0,        1));
        vecs.push_back(mk(0, 32'h1000, 32'h0,        MEM_WORD, 0, 32'h0,        1));
        vecs.push_back(mk(0, 32'h10,   32'h0,        MEM_WORD, 0, 32'h80ADBEEF, 0));
        vecs.push_back(mk(1, 32'h30,   32'h12345678, MEM_WORD, 0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h32,   32'hFFFFABCD, MEM_HALF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h30,   32'h0,        MEM_WORD, 0, 32'hABCD5678, 0));
        vecs.push_back(mk(0, 32'h32,   32'h0,        MEM_HALF, 0, 32'hFFFFABCD, 0));
        vecs.push_back(mk(0, 32'h32,   32'h0,        MEM_HALF, 1, 32'h0000ABCD, 0));
        vecs.push_back(mk(0, 32'h31,   32'h0,        MEM_BYTE, 0, 32'h00000056, 0));
        vecs.push_back(mk(0, 32'h30,   32'h0,        MEM_BYTE, 1, 32'h00000078, 0));
        vecs.push_back(mk(1, 32'h32,   32'h99999999, MEM_WORD, 0, 32'h0,        1));
        vecs.push_back(mk(0, 32'h30,   32'h0,        MEM_WORD, 0, 32'hABCD5678, 0));
        vecs.push_back(mk(1, 32'hFFC,  32'hCAFEF00D, MEM_WORD, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'hFFC,  32'h0,        MEM_WORD, 0, 32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 32'hFFE,  32'h0,        MEM_HALF, 0, 32'hFFFFCAFE, 0));
        vecs.push_back(mk(1, 32'hFFD,  32'hAAAAAA7F, MEM_BYTE, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'hFFC,  32'h0,        MEM_WORD, 0, 32'hCAFE7F0D, 0));
        vecs.push_back(mk(0, 32'h2000, 32'h0,        MEM_BYTE, 1, 32'h0,        1));

        rst_n = 1'b0;
        #1;
        check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", {31'b0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));

        // Reset during WAIT must cancel the pending store and its response.
        do_req(mk(1, 32'h20, 32'h22222222, MEM_WORD, 0, 32'h0, 0), "sw_first");
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111;
        req_size = MEM_WORD; req_usign = 1'b0; req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_no_ready", {31'b0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midreset_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_midreset", {31'b0, req_ready}, 32'd1);
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        check("cancelled_resp_pulses", 32'(pulses), 32'd0);
        do_req(mk(0, 32'h20, 32'h0, MEM_WORD, 0, 32'h22222222, 0), "lw_after_cancel");

        // LATENCY=0: back-to-back requests alternate ready every cycle.
        z_write = 1'b1; z_addr = 32'h0; z_wdata = 32'h5; z_size = MEM_WORD;
        z_valid = 1'b1;
        accepts = 0;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("z_ready_%0d", i), {31'b0, z_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (z_ready) accepts++;
            @(posedge clk); #1;
            if (z_resp_valid) pulses++;
        end
        z_valid = 1'b0;
        check("z_accepts", 32'(accepts), 32'd5);
        check("z_resp_pulses", 32'(pulses), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
